// File: rtl/pc_next_unit.sv
// Program-counter stage: sequential flow, JAL, JALR and conditional branches,
// with a single resolution bubble for branch/JALR while the ALU result lands.
module pc_next_unit #(
   parameter int unsigned           WORD_SIZE = 32,
   parameter logic [WORD_SIZE-1:0]  RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 is_branch,
   input  logic                 is_jal,
   input  logic                 is_jalr,
   input  logic [12:0]          br_off,
   input  logic [20:0]          jal_off,
   input  logic                 take_branch,
   input  logic [WORD_SIZE-1:0] alu_out,
   output logic [WORD_SIZE-1:0] pc,
   output logic                 pc_valid,
   output logic [WORD_SIZE-1:0] link_addr,
   output logic                 link_we,
   output logic                 misaligned
);

   typedef enum logic [1:0] {
      RUN,
      WAIT_BR,
      WAIT_JALR
   } state_t;

   state_t               state, state_nxt;
   logic [WORD_SIZE-1:0] target, target_nxt;
   logic [WORD_SIZE-1:0] fallthru, fallthru_nxt;
   logic [WORD_SIZE-1:0] pc_nxt, link_nxt;
   logic                 link_we_nxt, misaligned_nxt;

   logic [WORD_SIZE-1:0] pc_plus4, br_sext, jal_sext, jal_tgt, jalr_tgt, br_res;
   logic                 unused_lsbs;

   // Immediate bit 0 and the JALR result LSB are architecturally forced to zero.
   assign br_sext     = {{(WORD_SIZE-13){br_off[12]}}, br_off[12:1], 1'b0};
   assign jal_sext    = {{(WORD_SIZE-21){jal_off[20]}}, jal_off[20:1], 1'b0};
   assign jalr_tgt    = {alu_out[WORD_SIZE-1:1], 1'b0};
   assign pc_plus4    = pc + WORD_SIZE'(4);
   assign jal_tgt     = pc + jal_sext;
   assign br_res      = take_branch ? target : fallthru;
   assign unused_lsbs = ^{br_off[0], jal_off[0], alu_out[0]};

   assign pc_valid = (state == RUN);

   always_comb begin
      state_nxt      = state;
      pc_nxt         = pc;
      target_nxt     = target;
      fallthru_nxt   = fallthru;
      link_nxt       = link_addr;
      link_we_nxt    = 1'b0;
      misaligned_nxt = misaligned;
      case (state)
         RUN: begin
            if (!stall) begin
               if (is_jal) begin
                  pc_nxt      = jal_tgt;
                  link_nxt    = pc_plus4;
                  link_we_nxt = 1'b1;
                  if (jal_tgt[1]) misaligned_nxt = 1'b1;
               end else if (is_jalr) begin
                  link_nxt    = pc_plus4;
                  link_we_nxt = 1'b1;
                  state_nxt   = WAIT_JALR;
               end else if (is_branch) begin
                  target_nxt   = pc + br_sext;
                  fallthru_nxt = pc_plus4;
                  state_nxt    = WAIT_BR;
               end else begin
                  pc_nxt = pc_plus4;
               end
            end
         end
         WAIT_BR: begin
            // Not-taken is sequential flow and never flags misalignment.
            pc_nxt    = br_res;
            state_nxt = RUN;
            if (take_branch && target[1]) misaligned_nxt = 1'b1;
         end
         WAIT_JALR: begin
            pc_nxt    = jalr_tgt;
            state_nxt = RUN;
            if (jalr_tgt[1]) misaligned_nxt = 1'b1;
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= RUN;
         pc         <= RESET_PC;
         target     <= '0;
         fallthru   <= '0;
         link_addr  <= '0;
         link_we    <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         target     <= target_nxt;
         fallthru   <= fallthru_nxt;
         link_addr  <= link_nxt;
         link_we    <= link_we_nxt;
         misaligned <= misaligned_nxt;
      end
   end

endmodule
